// File: rtl/dbus_rr_arbiter_pkg.sv
// Shared types and sizing for the CPU dbus round-robin arbiter.
// Requester count and bus widths live here so the arbiter and its picker agree.
package dbus_rr_arbiter_pkg;

  localparam int N_CPU     = 3;
  localparam int DBUS_AW   = 32;
  localparam int DBUS_DW   = 32;
  localparam int DBUS_ISEL = 4;
  localparam int ARB_IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP, ARB_TURN} arb_state_e;

  function automatic logic [N_CPU-1:0] idx_onehot(input logic [ARB_IDX_W-1:0] idx);
    return {{(N_CPU-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Doubles the request vector so the rotate is a plain right shift.
module rr_grant_picker
  import dbus_rr_arbiter_pkg::*;
(
  input  logic [N_CPU-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic                 valid,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [2*N_CPU-1:0] req_dbl;
  logic [N_CPU-1:0]   req_rot;

  assign req_dbl = {req, req};

  always_comb begin
    int sum;
    req_rot = N_CPU'(req_dbl >> ptr);
    valid   = 1'b0;
    idx     = '0;
    sum     = 0;
    // Walk downward so the lowest rotated position (closest to ptr) wins.
    for (int i = N_CPU - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= N_CPU) sum = sum - N_CPU;
        idx   = ARB_IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream dbus port among N_CPU requesters.
// Optional ack deadline enabled by defining DBUS_ARB_TIMEOUT_EN (adds timeout_o).
//
//   state    | meaning
//   ARB_IDLE | pick eligible requester, capture its command
//   ARB_BUSY | downstream request held, waiting for ack_s2arb
//   ARB_RESP | ack pulse to the granted CPU, advance rr_ptr
//   ARB_TURN | turnaround gap, no new grant
module dbus_rr_arbiter
  import dbus_rr_arbiter_pkg::*;
#(
  parameter int TURNAROUND     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CPU-1:0]           req_m2arb,
  input  logic [N_CPU*DBUS_AW-1:0]   adr_m2arb_flat,
  input  logic [N_CPU*DBUS_DW-1:0]   dat_m2arb_flat,
  input  logic [N_CPU-1:0]           we_m2arb,
  input  logic [N_CPU*DBUS_ISEL-1:0] sel_m2arb_flat,
  output logic [N_CPU*DBUS_DW-1:0]   dat_arb2m_flat,
  output logic [N_CPU-1:0]           ack_arb2m,
  output logic                       req_arb2s,
  output logic [DBUS_AW-1:0]         adr_arb2s,
  output logic [DBUS_DW-1:0]         dat_arb2s,
  output logic                       we_arb2s,
  output logic [DBUS_ISEL-1:0]       sel_arb2s,
`ifdef DBUS_ARB_TIMEOUT_EN
  output logic                       timeout_o,
`endif
  input  logic                       ack_s2arb,
  input  logic [DBUS_DW-1:0]         dat_s2arb
);

  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] rr_ptr;
  logic [ARB_IDX_W-1:0] gnt_idx;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 pick_valid;
  logic [N_CPU-1:0]     mask;
  logic [N_CPU-1:0]     eligible;
  logic [TURN_W-1:0]    turn_cnt;
  logic                 grant_go;
  logic                 xfer_done;
  logic                 xfer_timeout;
  logic                 to_expired;

  assign eligible = req_m2arb & ~mask;

  rr_grant_picker u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Fires on the edge where the BUSY count would reach TIMEOUT_CYCLES.
  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= xfer_timeout;
      if (state_q == ARB_BUSY) to_cnt <= to_cnt + 1'b1;
      else                     to_cnt <= '0;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    grant_go     = 1'b0;
    xfer_done    = 1'b0;
    xfer_timeout = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_go = 1'b1;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A real ack on the expiry cycle takes precedence over the timeout.
        if (ack_s2arb) begin
          xfer_done = 1'b1;
          state_d   = ARB_RESP;
        end else if (to_expired) begin
          xfer_timeout = 1'b1;
          state_d      = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_TURN;
      ARB_TURN: begin
        if (turn_cnt == '0) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      mask           <= '0;
      turn_cnt       <= '0;
      req_arb2s      <= 1'b0;
      adr_arb2s      <= '0;
      dat_arb2s      <= '0;
      we_arb2s       <= 1'b0;
      sel_arb2s      <= '0;
      ack_arb2m      <= '0;
      dat_arb2m_flat <= '0;
    end else begin
      ack_arb2m <= '0;
      if (grant_go) begin
        req_arb2s <= 1'b1;
        gnt_idx   <= pick_idx;
        adr_arb2s <= adr_m2arb_flat[int'(pick_idx)*DBUS_AW +: DBUS_AW];
        dat_arb2s <= dat_m2arb_flat[int'(pick_idx)*DBUS_DW +: DBUS_DW];
        we_arb2s  <= we_m2arb[pick_idx];
        sel_arb2s <= sel_m2arb_flat[int'(pick_idx)*DBUS_ISEL +: DBUS_ISEL];
      end
      if (xfer_done || xfer_timeout) begin
        req_arb2s <= 1'b0;
        ack_arb2m <= idx_onehot(gnt_idx);
        dat_arb2m_flat[int'(gnt_idx)*DBUS_DW +: DBUS_DW] <= xfer_done ? dat_s2arb : '0;
      end
      if (state_q == ARB_RESP) begin
        rr_ptr   <= (gnt_idx == ARB_IDX_W'(N_CPU - 1)) ? '0 : gnt_idx + 1'b1;
        mask     <= idx_onehot(gnt_idx);
        turn_cnt <= TURN_W'(TURNAROUND - 1);
      end
      if (state_q == ARB_TURN) begin
        if (turn_cnt == '0) mask <= '0;
        else                turn_cnt <= turn_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Self-checking bench for dbus_rr_arbiter: directed scenarios plus a randomized
// run against a cycle-level round-robin model. Timeout scenario with DBUS_ARB_TIMEOUT_EN.
module tb_dbus_rr_arbiter;
  import dbus_rr_arbiter_pkg::*;

  localparam int N  = N_CPU;
  localparam int AW = DBUS_AW;
  localparam int DW = DBUS_DW;
  localparam int SW = DBUS_ISEL;
  localparam int TA = 2;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_m2arb = '0;
  logic [N*AW-1:0] adr_m2arb_flat = '0;
  logic [N*DW-1:0] dat_m2arb_flat = '0;
  logic [N-1:0]    we_m2arb = '0;
  logic [N*SW-1:0] sel_m2arb_flat = '0;
  logic [N*DW-1:0] dat_arb2m_flat;
  logic [N-1:0]    ack_arb2m;
  logic            req_arb2s;
  logic [AW-1:0]   adr_arb2s;
  logic [DW-1:0]   dat_arb2s;
  logic            we_arb2s;
  logic [SW-1:0]   sel_arb2s;
  logic            ack_s2arb = 1'b0;
  logic [DW-1:0]   dat_s2arb = '0;
`ifdef DBUS_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  dbus_rr_arbiter #(.TURNAROUND(TA), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_m2arb      (req_m2arb),
    .adr_m2arb_flat (adr_m2arb_flat),
    .dat_m2arb_flat (dat_m2arb_flat),
    .we_m2arb       (we_m2arb),
    .sel_m2arb_flat (sel_m2arb_flat),
    .dat_arb2m_flat (dat_arb2m_flat),
    .ack_arb2m      (ack_arb2m),
    .req_arb2s      (req_arb2s),
    .adr_arb2s      (adr_arb2s),
    .dat_arb2s      (dat_arb2s),
    .we_arb2s       (we_arb2s),
    .sel_arb2s      (sel_arb2s),
`ifdef DBUS_ARB_TIMEOUT_EN
    .timeout_o      (timeout_o),
`endif
    .ack_s2arb      (ack_s2arb),
    .dat_s2arb      (dat_s2arb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model: acks after slave_delay cycles of req_arb2s
  int          slave_delay = 3;
  bit          slave_never = 1'b0;
  int          slave_cnt = 0;
  int          sack_cyc = -1;
  logic [DW-1:0] slave_data = 32'h1111_0000;
  logic [DW-1:0] last_sdata = '0;
  bit [N-1:0]  auto_drop = '1;

  logic [AW-1:0] cpu_adr [N];
  logic [DW-1:0] cpu_dat [N];
  logic          cpu_we  [N];
  logic [SW-1:0] cpu_sel [N];

  task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [SW-1:0] s);
    cpu_adr[i] = a; cpu_dat[i] = d; cpu_we[i] = w; cpu_sel[i] = s;
    adr_m2arb_flat[i*AW +: AW] = a;
    dat_m2arb_flat[i*DW +: DW] = d;
    we_m2arb[i] = w;
    sel_m2arb_flat[i*SW +: SW] = s;
  endtask

  function automatic logic [DW-1:0] slice_of(input int i);
    return dat_arb2m_flat[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (ack_arb2m[i] === 1'b1 && auto_drop[i]) req_m2arb[i] = 1'b0;
    ack_s2arb = 1'b0;
    dat_s2arb = $urandom;
    if (req_arb2s === 1'b1) begin
      if (!slave_never && slave_cnt == slave_delay) begin
        ack_s2arb  = 1'b1;
        dat_s2arb  = slave_data;
        last_sdata = slave_data;
        slave_data = $urandom;
        sack_cyc   = cyc;
      end
      slave_cnt++;
    end else begin
      slave_cnt = 0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_m2arb = '0;
    slave_never = 1'b0;
    slave_delay = 3;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_m2arb = '1;
    tick();
    tick();
    tick();
    checks++;
    if ({req_arb2s, we_arb2s, ack_arb2m, adr_arb2s, dat_arb2s, sel_arb2s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b ack=%b adr=%h dat=%h we=%b sel=%h want all 0",
               req_arb2s, ack_arb2m, adr_arb2s, dat_arb2s, we_arb2s, sel_arb2s);
    end
    checks++;
    if (dat_arb2m_flat !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", dat_arb2m_flat);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int t0, n_ack, ack_cyc;
    logic [N-1:0] ack_v;
    logic [DW-1:0] rd;
    apply_reset();
    set_cmd(0, '0, 32'h5555_AAAA, 1'b0, '1);
    slave_data = 32'hCAFE_0000;
    slave_delay = 3;
    req_m2arb[0] = 1'b1;
    t0 = cyc;
    tick();
    checks++;
    if (req_arb2s !== 1'b1) begin
      errors++;
      $display("FAIL single_req_latency got %b want 1", req_arb2s);
    end
    checks++;
    if ({adr_arb2s, we_arb2s, sel_arb2s} !== {AW'(0), 1'b0, {SW{1'b1}}}) begin
      errors++;
      $display("FAIL single_cmd got adr=%h we=%b sel=%h want adr=0 we=0 sel=all-ones",
               adr_arb2s, we_arb2s, sel_arb2s);
    end
    n_ack = 0; ack_cyc = -1; ack_v = '0; rd = '0;
    for (int k = 0; k < 15; k++) begin
      if (ack_arb2m !== '0) begin
        n_ack++;
        if (ack_cyc < 0) begin ack_cyc = cyc; ack_v = ack_arb2m; rd = slice_of(0); end
      end
      tick();
    end
    checks++;
    if (n_ack != 1) begin errors++; $display("FAIL single_ack_count got %0d want 1", n_ack); end
    checks++;
    if (ack_v !== 3'b001) begin errors++; $display("FAIL single_ack_vec got %b want 001", ack_v); end
    checks++;
    if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL single_rdata got %h want cafe0000", rd); end
    checks++;
    if (ack_cyc != t0 + 5) begin
      errors++;
      $display("FAIL single_ack_cycle got %0d want %0d", ack_cyc - t0, 5);
    end
  endtask

  task automatic test_all_three();
    int q_idx[$], q_cyc[$], multi;
    logic [DW-1:0] q_dat[$], q_exp[$];
    apply_reset();
    for (int i = 0; i < N; i++) set_cmd(i, AW'($urandom), DW'($urandom), 1'b0, SW'($urandom));
    req_m2arb = '1;
    multi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if ($countones(ack_arb2m) > 1) multi++;
      for (int i = 0; i < N; i++)
        if (ack_arb2m[i] === 1'b1) begin
          q_idx.push_back(i); q_cyc.push_back(cyc);
          q_dat.push_back(slice_of(i)); q_exp.push_back(last_sdata);
        end
    end
    checks++;
    if (multi != 0) begin errors++; $display("FAIL all3_multihot got %0d cycles want 0", multi); end
    checks++;
    if (q_idx.size() != 3) begin errors++; $display("FAIL all3_ack_count got %0d want 3", q_idx.size()); end
    for (int k = 0; k < q_idx.size() && k < 3; k++) begin
      checks++;
      if (q_idx[k] != k) begin errors++; $display("FAIL all3_order pos %0d got cpu%0d want cpu%0d", k, q_idx[k], k); end
      checks++;
      if (q_dat[k] !== q_exp[k]) begin errors++; $display("FAIL all3_rdata pos %0d got %h want %h", k, q_dat[k], q_exp[k]); end
      if (k > 0) begin
        checks++;
        if (q_cyc[k] - q_cyc[k-1] != TA + 6) begin
          errors++;
          $display("FAIL all3_gap pos %0d got %0d want %0d", k, q_cyc[k] - q_cyc[k-1], TA + 6);
        end
      end
    end
  endtask

  task automatic test_write();
    int busy_cyc, n_ack, bad;
    logic [N-1:0] ack_v;
    apply_reset();
    set_cmd(1, 32'h10, 32'h1234_5678, 1'b1, 4'b0011);
    req_m2arb[1] = 1'b1;
    busy_cyc = 0; n_ack = 0; bad = 0; ack_v = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (req_arb2s === 1'b1) begin
        busy_cyc++;
        if ({adr_arb2s, dat_arb2s, we_arb2s, sel_arb2s} !== {32'h10, 32'h1234_5678, 1'b1, 4'b0011}) bad++;
      end
      if (ack_arb2m !== '0) begin n_ack++; ack_v = ack_arb2m; end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL write_cmd_stable got %0d bad cycles want 0", bad); end
    checks++;
    if (busy_cyc != 4) begin errors++; $display("FAIL write_busy_len got %0d want 4", busy_cyc); end
    checks++;
    if (n_ack != 1 || ack_v !== 3'b010) begin
      errors++;
      $display("FAIL write_ack got count=%0d vec=%b want count=1 vec=010", n_ack, ack_v);
    end
  endtask

  task automatic test_hold_after_ack();
    int r, rise, n0, n2;
    logic [AW-1:0] rise_adr;
    apply_reset();
    auto_drop[2] = 1'b0;
    set_cmd(2, 32'h200, DW'($urandom), 1'b0, '1);
    set_cmd(0, 32'h40, DW'($urandom), 1'b1, 4'b1100);
    req_m2arb[2] = 1'b1;
    r = -1;
    for (int k = 0; k < 15 && r < 0; k++) begin
      tick();
      if (ack_arb2m[2] === 1'b1) r = cyc;
    end
    checks++;
    if (r < 0) begin errors++; $display("FAIL hold_first_ack got none want ack within 15 cycles"); end
    req_m2arb[0] = 1'b1;
    tick();
    tick();
    req_m2arb[2] = 1'b0;
    rise = -1; n0 = 0; n2 = 0; rise_adr = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (req_arb2s === 1'b1 && rise < 0) begin rise = cyc; rise_adr = adr_arb2s; end
      if (ack_arb2m[0] === 1'b1) n0++;
      if (ack_arb2m[2] === 1'b1) n2++;
    end
    checks++;
    if (rise != r + TA + 2) begin errors++; $display("FAIL hold_next_grant_cycle got %0d want %0d", rise - r, TA + 2); end
    checks++;
    if (rise_adr !== 32'h40) begin errors++; $display("FAIL hold_next_grant_adr got %h want 00000040", rise_adr); end
    checks++;
    if (n0 != 1 || n2 != 0) begin
      errors++;
      $display("FAIL hold_acks got cpu0=%0d cpu2=%0d want cpu0=1 cpu2=0", n0, n2);
    end
    auto_drop[2] = 1'b1;
  endtask

  task automatic test_reset_busy();
    bit done;
    int n_ack, n_req;
    apply_reset();
    set_cmd(0, 32'h80, DW'($urandom), 1'b0, '1);
    req_m2arb[0] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 15 && !done; k++) begin
      tick();
      if (ack_arb2m[0] === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL rstbusy_pre_ack got none want cpu0 ack"); end
    repeat (4) tick();
    set_cmd(1, 32'hC0, DW'($urandom), 1'b1, 4'b0101);
    set_cmd(0, 32'h84, DW'($urandom), 1'b0, 4'b1111);
    slave_delay = 20;
    req_m2arb[1] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (req_arb2s !== 1'b1 || adr_arb2s !== 32'hC0) begin
      errors++;
      $display("FAIL rstbusy_pre_grant got req=%b adr=%h want req=1 adr=000000c0", req_arb2s, adr_arb2s);
    end
    reset = 1'b1;
    req_m2arb = '0;
    tick();
    checks++;
    if ({req_arb2s, we_arb2s, ack_arb2m, adr_arb2s, dat_arb2s, sel_arb2s} !== '0 || dat_arb2m_flat !== '0) begin
      errors++;
      $display("FAIL rstbusy_outputs got req=%b ack=%b adr=%h rdata=%h want all 0",
               req_arb2s, ack_arb2m, adr_arb2s, dat_arb2m_flat);
    end
    reset = 1'b0;
    ack_s2arb = 1'b1;
    dat_s2arb = 32'hDEAD_BEEF;
    n_ack = 0; n_req = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack_arb2m !== '0) n_ack++;
      if (req_arb2s !== 1'b0) n_req++;
    end
    checks++;
    if (n_ack != 0 || n_req != 0) begin
      errors++;
      $display("FAIL rstbusy_stray_ack got acks=%0d req_cycles=%0d want 0 0", n_ack, n_req);
    end
    slave_delay = 3;
    req_m2arb[0] = 1'b1;
    req_m2arb[1] = 1'b1;
    tick();
    checks++;
    if (req_arb2s !== 1'b1 || adr_arb2s !== 32'h84) begin
      errors++;
      $display("FAIL rstbusy_ptr_reset got req=%b adr=%h want req=1 adr=00000084", req_arb2s, adr_arb2s);
    end
  endtask

  task automatic test_random();
    int idle_from, win, ptr, ack_due, c;
    bit exp_req, found;
    logic [DW-1:0] exp_data;
    logic [N-1:0] oh;
    apply_reset();
    ptr = 0; win = 0; exp_req = 1'b0; ack_due = -1; idle_from = cyc; exp_data = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (req_m2arb[i] == 1'b0 && $urandom_range(2) == 0) begin
          set_cmd(i, AW'($urandom), DW'($urandom), 1'($urandom_range(1)), SW'($urandom));
          req_m2arb[i] = 1'b1;
        end
      if (!exp_req && cyc >= idle_from && req_m2arb != '0) begin
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          c = (ptr + j) % N;
          if (!found && req_m2arb[c]) begin win = c; found = 1'b1; end
        end
        ptr = (win + 1) % N;
        exp_req = 1'b1;
        idle_from = 1 << 30;
        slave_delay = $urandom_range(4);
      end
      tick();
      checks++;
      if (req_arb2s !== exp_req) begin
        errors++;
        $display("FAIL rand_req cyc %0d got %b want %b", cyc, req_arb2s, exp_req);
      end
      if (exp_req) begin
        checks++;
        if ({adr_arb2s, dat_arb2s, we_arb2s, sel_arb2s} !== {cpu_adr[win], cpu_dat[win], cpu_we[win], cpu_sel[win]}) begin
          errors++;
          $display("FAIL rand_cmd cyc %0d got adr=%h dat=%h we=%b sel=%h want cpu%0d adr=%h dat=%h we=%b sel=%h",
                   cyc, adr_arb2s, dat_arb2s, we_arb2s, sel_arb2s, win,
                   cpu_adr[win], cpu_dat[win], cpu_we[win], cpu_sel[win]);
        end
      end
      oh = '0;
      if (cyc == ack_due) oh[win] = 1'b1;
      checks++;
      if (ack_arb2m !== oh) begin
        errors++;
        $display("FAIL rand_ack cyc %0d got %b want %b", cyc, ack_arb2m, oh);
      end
      if (cyc == ack_due) begin
        checks++;
        if (slice_of(win) !== exp_data) begin
          errors++;
          $display("FAIL rand_rdata cyc %0d cpu%0d got %h want %h", cyc, win, slice_of(win), exp_data);
        end
      end
`ifdef DBUS_ARB_TIMEOUT_EN
      checks++;
      if (timeout_o !== 1'b0) begin errors++; $display("FAIL rand_timeout cyc %0d got %b want 0", cyc, timeout_o); end
`endif
      if (exp_req && ack_s2arb) begin
        exp_req = 1'b0;
        ack_due = cyc + 1;
        exp_data = dat_s2arb;
        idle_from = cyc + TA + 2;
      end
    end
  endtask

`ifdef DBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0, ack_cyc, n_to, to_cyc;
    logic [DW-1:0] rd, exp_rd;
    logic req_at_ack;
    apply_reset();
    set_cmd(0, 32'h300, DW'($urandom), 1'b0, '1);
    slave_data = 32'h7777_0001;
    req_m2arb[0] = 1'b1;
    repeat (12) tick();
    checks++;
    if (slice_of(0) !== 32'h7777_0001) begin errors++; $display("FAIL to_pre_rdata got %h want 77770001", slice_of(0)); end
    slave_never = 1'b1;
    req_m2arb[0] = 1'b1;
    t0 = cyc; ack_cyc = -1; n_to = 0; to_cyc = -1; rd = '1; req_at_ack = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (timeout_o === 1'b1) begin n_to++; to_cyc = cyc; end
      if (ack_arb2m[0] === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; rd = slice_of(0); req_at_ack = req_arb2s; end
    end
    checks++;
    if (ack_cyc != t0 + TO + 1) begin errors++; $display("FAIL to_ack_cycle got %0d want %0d", ack_cyc - t0, TO + 1); end
    checks++;
    if (n_to != 1 || to_cyc != ack_cyc) begin
      errors++;
      $display("FAIL to_pulse got count=%0d at %0d want count=1 at ack cycle %0d", n_to, to_cyc, ack_cyc);
    end
    checks++;
    if (rd !== '0 || req_at_ack !== 1'b0) begin
      errors++;
      $display("FAIL to_rdata got data=%h req=%b want data=0 req=0", rd, req_at_ack);
    end
    slave_never = 1'b0;
    slave_delay = TO - 1;
    slave_data = 32'hA5A5_0001;
    exp_rd = 32'hA5A5_0001;
    req_m2arb[0] = 1'b1;
    t0 = cyc; ack_cyc = -1; n_to = 0; rd = '0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (timeout_o === 1'b1) n_to++;
      if (ack_arb2m[0] === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; rd = slice_of(0); end
    end
    checks++;
    if (ack_cyc != t0 + TO + 1 || n_to != 0) begin
      errors++;
      $display("FAIL to_edge_ack got cycle=%0d timeouts=%0d want cycle=%0d timeouts=0", ack_cyc - t0, n_to, TO + 1);
    end
    checks++;
    if (rd !== exp_rd) begin errors++; $display("FAIL to_edge_rdata got %h want %h", rd, exp_rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_all_three();
    test_write();
    test_hold_after_ack();
    test_reset_busy();
    test_random();
`ifdef DBUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
